// File: rtl/mcy_mutsel_pkg.sv
// Shared types for the mutation-select controller: channel state encoding,
// the "unmutated" select value and the configuration-open predicate.
package mcy_mutsel_pkg;

    typedef enum logic [2:0] {
        CH_IDLE   = 3'd0,
        CH_LOADED = 3'd1,
        CH_ARMED  = 3'd2,
        CH_ACTIVE = 3'd3,
        CH_DONE   = 3'd4
    } chan_state_t;

    localparam int MUTSEL_NONE = 0;

    // A channel only takes a new configuration once it is idle or has finished.
    function automatic logic cfg_open(input chan_state_t s);
        return (s == CH_IDLE) || (s == CH_DONE);
    endfunction

endpackage

// File: rtl/mcy_mutsel_chan.sv
// One mutation channel: latches a configuration, waits the programmed delay
// after start, then drives its mutation index for len cycles (0 = forever).
module mcy_mutsel_chan
    import mcy_mutsel_pkg::*;
#(
    parameter int MUTSEL_W = 8,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [MUTSEL_W-1:0] load_idx,
    input  logic [CNT_W-1:0]    load_delay,
    input  logic [CNT_W-1:0]    load_len,
    input  logic                start,
    input  logic                abort,
    output chan_state_t         state,
    output logic [MUTSEL_W-1:0] mutsel,
    output logic                active,
    output logic                done
);

    logic [MUTSEL_W-1:0] idx_q;
    logic [CNT_W-1:0]    delay_q;
    logic [CNT_W-1:0]    len_q;
    logic [CNT_W-1:0]    cnt;

    // Abort shares the reset path so it wins over start, expiry and load alike.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            state   <= CH_IDLE;
            idx_q   <= '0;
            delay_q <= '0;
            len_q   <= '0;
            cnt     <= '0;
            mutsel  <= MUTSEL_W'(MUTSEL_NONE);
            active  <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                CH_IDLE, CH_DONE: begin
                    if (load) begin
                        state   <= CH_LOADED;
                        idx_q   <= load_idx;
                        delay_q <= load_delay;
                        len_q   <= load_len;
                        done    <= 1'b0;
                    end
                end
                CH_LOADED: begin
                    if (start) begin
                        if (delay_q == '0) begin
                            state  <= CH_ACTIVE;
                            mutsel <= idx_q;
                            active <= 1'b1;
                            cnt    <= len_q;
                        end else begin
                            state <= CH_ARMED;
                            cnt   <= delay_q;
                        end
                    end
                end
                CH_ARMED: begin
                    // Counter holds the cycles still to wait; at 1 the next cycle is active.
                    if (cnt == CNT_W'(1)) begin
                        state  <= CH_ACTIVE;
                        mutsel <= idx_q;
                        active <= 1'b1;
                        cnt    <= len_q;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                CH_ACTIVE: begin
                    if (len_q != '0) begin
                        if (cnt == CNT_W'(1)) begin
                            state  <= CH_DONE;
                            mutsel <= MUTSEL_W'(MUTSEL_NONE);
                            active <= 1'b0;
                            done   <= 1'b1;
                            cnt    <= '0;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state  <= CH_IDLE;
                    mutsel <= MUTSEL_W'(MUTSEL_NONE);
                    active <= 1'b0;
                    done   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mcy_mutsel_ctrl.sv
// Multi-channel mutation-select controller: configuration demux, ready mux and
// optional simulator back door (define MCY_MUTSEL_DPI_EN to export set_mutsel).
module mcy_mutsel_ctrl
    import mcy_mutsel_pkg::*;
#(
    parameter int MUTSEL_W = 8,
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cfg_valid_i,
    output logic                              cfg_ready_o,
    input  logic [$clog2(NUM_CH)-1:0]         cfg_ch_i,
    input  logic [MUTSEL_W-1:0]               cfg_idx_i,
    input  logic [CNT_W-1:0]                  cfg_delay_i,
    input  logic [CNT_W-1:0]                  cfg_len_i,
    input  logic [NUM_CH-1:0]                 start_i,
    input  logic [NUM_CH-1:0]                 abort_i,
    output logic [NUM_CH-1:0][MUTSEL_W-1:0]   mutsel_o,
    output logic [NUM_CH-1:0]                 active_o,
    output logic [NUM_CH-1:0]                 done_o
);

    localparam int CH_W = $clog2(NUM_CH);

    chan_state_t         chan_state [NUM_CH];
    logic                ch_in_range;
    logic [NUM_CH-1:0]   port_load;
    logic [NUM_CH-1:0]   dpi_load;
    logic [NUM_CH-1:0]   dpi_start;
    logic [MUTSEL_W-1:0] dpi_idx;
    logic [CNT_W-1:0]    dpi_delay;
    logic [CNT_W-1:0]    dpi_len;

    assign ch_in_range = ({1'b0, cfg_ch_i} < (CH_W+1)'(NUM_CH));

    always_comb begin
        cfg_ready_o = 1'b0;
        if (ch_in_range) begin
            cfg_ready_o = cfg_open(chan_state[cfg_ch_i]) && !abort_i[cfg_ch_i];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            port_load[i] = cfg_valid_i && cfg_ready_o && (cfg_ch_i == CH_W'(i));
        end
    end

`ifdef MCY_MUTSEL_DPI_EN
    logic                dpi_req;
    int                  dpi_ch;
    logic [NUM_CH-1:0]   dpi_start_q;

    // Holds the request for exactly one rising edge, then the start follows one cycle later.
    task automatic set_mutsel(input int ch, input int idx, input int delay, input int len);
        @(negedge clk);
        dpi_ch    = ch;
        dpi_idx   = MUTSEL_W'(idx);
        dpi_delay = CNT_W'(delay);
        dpi_len   = CNT_W'(len);
        dpi_req   = 1'b1;
        @(negedge clk);
        dpi_req   = 1'b0;
    endtask

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            dpi_load[i] = (dpi_req === 1'b1) && (dpi_ch == i) && !abort_i[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dpi_start_q <= '0;
        end else begin
            dpi_start_q <= dpi_load;
        end
    end

    assign dpi_start = dpi_start_q;
`else
    assign dpi_load  = '0;
    assign dpi_start = '0;
    assign dpi_idx   = '0;
    assign dpi_delay = '0;
    assign dpi_len   = '0;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        logic [MUTSEL_W-1:0] ld_idx;
        logic [CNT_W-1:0]    ld_delay;
        logic [CNT_W-1:0]    ld_len;

        // The back door overrides a port request aimed at the same channel.
        assign ld_idx   = dpi_load[g] ? dpi_idx   : cfg_idx_i;
        assign ld_delay = dpi_load[g] ? dpi_delay : cfg_delay_i;
        assign ld_len   = dpi_load[g] ? dpi_len   : cfg_len_i;

        mcy_mutsel_chan #(
            .MUTSEL_W (MUTSEL_W),
            .CNT_W    (CNT_W)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .load       (port_load[g] || dpi_load[g]),
            .load_idx   (ld_idx),
            .load_delay (ld_delay),
            .load_len   (ld_len),
            .start      (start_i[g] || dpi_start[g]),
            .abort      (abort_i[g]),
            .state      (chan_state[g]),
            .mutsel     (mutsel_o[g]),
            .active     (active_o[g]),
            .done       (done_o[g])
        );
    end

endmodule

// File: tb/tb_mcy_mutsel_ctrl.sv
// Scenario bench for mcy_mutsel_ctrl: per-cycle expectations are queued when a
// channel is started and popped against the outputs as the cycles elapse.
module tb_mcy_mutsel_ctrl;

    typedef struct {
        int         ch;
        logic [7:0] mutsel;
        logic       active;
        logic       done;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             cfg_valid_i;
    logic             cfg_ready_o;
    logic [1:0]       cfg_ch_i;
    logic [7:0]       cfg_idx_i;
    logic [15:0]      cfg_delay_i;
    logic [15:0]      cfg_len_i;
    logic [3:0]       start_i;
    logic [3:0]       abort_i;
    logic [3:0][7:0]  mutsel_o;
    logic [3:0]       active_o;
    logic [3:0]       done_o;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    mcy_mutsel_ctrl #(
        .MUTSEL_W (8),
        .NUM_CH   (4),
        .CNT_W    (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid_i (cfg_valid_i),
        .cfg_ready_o (cfg_ready_o),
        .cfg_ch_i    (cfg_ch_i),
        .cfg_idx_i   (cfg_idx_i),
        .cfg_delay_i (cfg_delay_i),
        .cfg_len_i   (cfg_len_i),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .mutsel_o    (mutsel_o),
        .active_o    (active_o),
        .done_o      (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input int ch, input logic [7:0] idx, input logic [15:0] dly, input logic [15:0] len);
        cfg_valid_i = 1'b1;
        cfg_ch_i    = 2'(ch);
        cfg_idx_i   = idx;
        cfg_delay_i = dly;
        cfg_len_i   = len;
        tick();
        cfg_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cfg_valid_i = 1'b0; cfg_ch_i = 2'd0; cfg_idx_i = 8'd0;
        cfg_delay_i = 16'd0; cfg_len_i = 16'd0; start_i = 4'd0; abort_i = 4'd0;
        tick(); tick();
        rst = 1'b0;
        #1;
        checks++; if (mutsel_o !== 32'd0) begin errors++; $display("[TB] FAIL reset_mutsel got %h want 0", mutsel_o); end
        checks++; if (active_o !== 4'd0) begin errors++; $display("[TB] FAIL reset_active got %b want 0000", active_o); end
        checks++; if (done_o !== 4'd0) begin errors++; $display("[TB] FAIL reset_done got %b want 0000", done_o); end
        checks++; if (cfg_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b want 1", cfg_ready_o); end
    endtask

    task automatic test_delayed_activation();
        exp_t e;
        load_cfg(0, 8'd5, 16'd3, 16'd4);
        for (int k = 1; k <= 9; k++)
            exp_q.push_back('{ch: 0, mutsel: (k >= 4 && k <= 7) ? 8'd5 : 8'd0,
                              active: (k >= 4 && k <= 7), done: (k >= 8)});
        start_i[0] = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            start_i = 4'd0;
            e = exp_q.pop_front();
            checks++; if (mutsel_o[e.ch] !== e.mutsel) begin errors++; $display("[TB] FAIL delay_mutsel T+%0d got %h want %h", k, mutsel_o[e.ch], e.mutsel); end
            checks++; if (active_o[e.ch] !== e.active) begin errors++; $display("[TB] FAIL delay_active T+%0d got %b want %b", k, active_o[e.ch], e.active); end
            checks++; if (done_o[e.ch] !== e.done) begin errors++; $display("[TB] FAIL delay_done T+%0d got %b want %b", k, done_o[e.ch], e.done); end
        end
    endtask

    task automatic test_permanent();
        exp_t e;
        load_cfg(1, 8'hA7, 16'd0, 16'd0);
        for (int k = 1; k <= 1000; k++)
            exp_q.push_back('{ch: 1, mutsel: 8'hA7, active: 1'b1, done: 1'b0});
        start_i[1] = 1'b1;
        for (int k = 1; k <= 1000; k++) begin
            tick();
            start_i = 4'd0;
            e = exp_q.pop_front();
            checks++; if (mutsel_o[e.ch] !== e.mutsel) begin errors++; $display("[TB] FAIL perm_mutsel T+%0d got %h want %h", k, mutsel_o[e.ch], e.mutsel); end
            checks++; if (active_o[e.ch] !== e.active) begin errors++; $display("[TB] FAIL perm_active T+%0d got %b want %b", k, active_o[e.ch], e.active); end
        end
        abort_i[1] = 1'b1;
        tick();
        abort_i = 4'd0;
        checks++; if (mutsel_o[1] !== 8'd0) begin errors++; $display("[TB] FAIL perm_abort_mutsel got %h want 00", mutsel_o[1]); end
        checks++; if (active_o[1] !== 1'b0) begin errors++; $display("[TB] FAIL perm_abort_active got %b want 0", active_o[1]); end
        checks++; if (done_o[1] !== 1'b0) begin errors++; $display("[TB] FAIL perm_abort_done got %b want 0", done_o[1]); end
    endtask

    task automatic test_cfg_while_armed();
        exp_t e;
        load_cfg(2, 8'h09, 16'd5, 16'd2);
        for (int k = 1; k <= 9; k++)
            exp_q.push_back('{ch: 2, mutsel: (k == 6 || k == 7) ? 8'h09 : 8'h00,
                              active: (k == 6 || k == 7), done: (k >= 8)});
        start_i[2] = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            start_i = 4'd0;
            e = exp_q.pop_front();
            checks++; if (mutsel_o[e.ch] !== e.mutsel) begin errors++; $display("[TB] FAIL armed_mutsel T+%0d got %h want %h", k, mutsel_o[e.ch], e.mutsel); end
            checks++; if (done_o[e.ch] !== e.done) begin errors++; $display("[TB] FAIL armed_done T+%0d got %b want %b", k, done_o[e.ch], e.done); end
            if (k == 2) begin
                cfg_valid_i = 1'b1; cfg_ch_i = 2'd2; cfg_idx_i = 8'h33;
                cfg_delay_i = 16'd0; cfg_len_i = 16'd1;
                #1;
                checks++; if (cfg_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL armed_ready got %b want 0", cfg_ready_o); end
            end
            if (k == 3) cfg_valid_i = 1'b0;
        end
        cfg_valid_i = 1'b1; cfg_ch_i = 2'd2; cfg_idx_i = 8'h33;
        cfg_delay_i = 16'd0; cfg_len_i = 16'd1;
        #1;
        checks++; if (cfg_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL retry_ready got %b want 1", cfg_ready_o); end
        tick();
        cfg_valid_i = 1'b0;
        exp_q.push_back('{ch: 2, mutsel: 8'h33, active: 1'b1, done: 1'b0});
        exp_q.push_back('{ch: 2, mutsel: 8'h00, active: 1'b0, done: 1'b1});
        start_i[2] = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            tick();
            start_i = 4'd0;
            e = exp_q.pop_front();
            checks++; if (mutsel_o[e.ch] !== e.mutsel) begin errors++; $display("[TB] FAIL retry_mutsel T+%0d got %h want %h", k, mutsel_o[e.ch], e.mutsel); end
            checks++; if (done_o[e.ch] !== e.done) begin errors++; $display("[TB] FAIL retry_done T+%0d got %b want %b", k, done_o[e.ch], e.done); end
        end
    endtask

    task automatic test_idx_zero();
        exp_t e;
        load_cfg(1, 8'h00, 16'd1, 16'd2);
        for (int k = 1; k <= 5; k++)
            exp_q.push_back('{ch: 1, mutsel: 8'h00, active: (k == 2 || k == 3), done: (k >= 4)});
        start_i[1] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            start_i = 4'd0;
            e = exp_q.pop_front();
            checks++; if (mutsel_o[e.ch] !== e.mutsel) begin errors++; $display("[TB] FAIL idx0_mutsel T+%0d got %h want %h", k, mutsel_o[e.ch], e.mutsel); end
            checks++; if (active_o[e.ch] !== e.active) begin errors++; $display("[TB] FAIL idx0_active T+%0d got %b want %b", k, active_o[e.ch], e.active); end
            checks++; if (done_o[e.ch] !== e.done) begin errors++; $display("[TB] FAIL idx0_done T+%0d got %b want %b", k, done_o[e.ch], e.done); end
        end
    endtask

    task automatic test_reset_mid_active();
        logic [3:0][7:0] want;
        want = {8'd4, 8'd3, 8'd2, 8'd1};
        for (int c = 0; c < 4; c++) load_cfg(c, 8'(c + 1), 16'd0, 16'd0);
        start_i = 4'hF;
        tick();
        start_i = 4'd0;
        tick(); tick();
        checks++; if (active_o !== 4'hF) begin errors++; $display("[TB] FAIL all_active got %b want 1111", active_o); end
        checks++; if (mutsel_o !== want) begin errors++; $display("[TB] FAIL all_mutsel got %h want %h", mutsel_o, want); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (mutsel_o !== 32'd0) begin errors++; $display("[TB] FAIL rst_mid_mutsel got %h want 0", mutsel_o); end
        checks++; if (active_o !== 4'd0) begin errors++; $display("[TB] FAIL rst_mid_active got %b want 0000", active_o); end
        checks++; if (done_o !== 4'd0) begin errors++; $display("[TB] FAIL rst_mid_done got %b want 0000", done_o); end
        start_i = 4'hF;
        tick();
        start_i = 4'd0;
        tick();
        checks++; if (active_o !== 4'd0) begin errors++; $display("[TB] FAIL rst_start_active got %b want 0000", active_o); end
        checks++; if (mutsel_o !== 32'd0) begin errors++; $display("[TB] FAIL rst_start_mutsel got %h want 0", mutsel_o); end
    endtask

    task automatic test_abort_vs_cfg();
        cfg_valid_i = 1'b1; cfg_ch_i = 2'd3; cfg_idx_i = 8'h55;
        cfg_delay_i = 16'd0; cfg_len_i = 16'd0;
        abort_i = 4'b1000;
        #1;
        checks++; if (cfg_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL abortcfg_ready got %b want 0", cfg_ready_o); end
        tick();
        cfg_valid_i = 1'b0;
        abort_i = 4'd0;
        start_i[3] = 1'b1;
        tick();
        start_i = 4'd0;
        tick();
        checks++; if (active_o[3] !== 1'b0) begin errors++; $display("[TB] FAIL abortcfg_active got %b want 0", active_o[3]); end
        checks++; if (mutsel_o[3] !== 8'd0) begin errors++; $display("[TB] FAIL abortcfg_mutsel got %h want 00", mutsel_o[3]); end
        load_cfg(3, 8'h66, 16'd0, 16'd0);
        start_i[3] = 1'b1;
        abort_i[3] = 1'b1;
        tick();
        start_i = 4'd0;
        abort_i = 4'd0;
        checks++; if (active_o[3] !== 1'b0) begin errors++; $display("[TB] FAIL abortstart_active got %b want 0", active_o[3]); end
        start_i[3] = 1'b1;
        tick();
        start_i = 4'd0;
        checks++; if (mutsel_o[3] !== 8'd0) begin errors++; $display("[TB] FAIL idle_start_mutsel got %h want 00", mutsel_o[3]); end
        cfg_ch_i = 2'd3;
        #1;
        checks++; if (cfg_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL abort_idle_ready got %b want 1", cfg_ready_o); end
    endtask

    task automatic test_long_delay();
        exp_t e;
        int early;
        early = 0;
        load_cfg(0, 8'hC3, 16'hFFFF, 16'd2);
        exp_q.push_back('{ch: 0, mutsel: 8'h00, active: 1'b0, done: 1'b0});
        exp_q.push_back('{ch: 0, mutsel: 8'hC3, active: 1'b1, done: 1'b0});
        exp_q.push_back('{ch: 0, mutsel: 8'hC3, active: 1'b1, done: 1'b0});
        exp_q.push_back('{ch: 0, mutsel: 8'h00, active: 1'b0, done: 1'b1});
        start_i[0] = 1'b1;
        for (int k = 1; k <= 65538; k++) begin
            tick();
            start_i = 4'd0;
            if (k < 65535 && (mutsel_o[0] !== 8'd0 || active_o[0] !== 1'b0 || done_o[0] !== 1'b0)) early++;
            if (k >= 65535) begin
                e = exp_q.pop_front();
                checks++; if (mutsel_o[e.ch] !== e.mutsel) begin errors++; $display("[TB] FAIL long_mutsel T+%0d got %h want %h", k, mutsel_o[e.ch], e.mutsel); end
                checks++; if (active_o[e.ch] !== e.active) begin errors++; $display("[TB] FAIL long_active T+%0d got %b want %b", k, active_o[e.ch], e.active); end
                checks++; if (done_o[e.ch] !== e.done) begin errors++; $display("[TB] FAIL long_done T+%0d got %b want %b", k, done_o[e.ch], e.done); end
            end
        end
        checks++; if (early != 0) begin errors++; $display("[TB] FAIL long_early got %0d cycles want 0", early); end
    endtask

    initial begin
        $display("[TB] starting mcy_mutsel_ctrl scenarios");
        test_reset();
        test_delayed_activation();
        test_permanent();
        test_cfg_while_armed();
        test_idx_zero();
        test_reset_mid_active();
        test_abort_vs_cfg();
        test_long_delay();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
